// File: rtl/lcd_line_arbiter.sv
// Character-LCD write sequencer: power-up wait, controller init, then round-robin
// whole-line writes from two producers, each byte sent as SETUP / EN-high / wait.
module lcd_line_arbiter #(
  parameter int EN_HIGH_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLR_WAIT_CYC   = 82000,
  parameter int PWRUP_WAIT_CYC = 750000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [127:0] line0,
  input  logic         req1,
  input  logic [127:0] line1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic         ready,
  output logic         busy,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data
);

  localparam int MAX_A   = (PWRUP_WAIT_CYC > CLR_WAIT_CYC) ? PWRUP_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > EN_HIGH_CYC) ? CMD_WAIT_CYC : EN_HIGH_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(PWRUP_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD  = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_CHAR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             ready_q, ready_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [127:0]     line_q, line_d;
  logic             grant0, grant1;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // On a tie the side not served last wins; last_q resets to 1 so line 0 wins first.
  assign grant0 = req0 && (!req1 || last_q);
  assign grant1 = req1 && !grant0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWRUP;
      phase_q <= PH_SETUP;
      cnt_q   <= PWR_LD;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      ready_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  // Line buffer is pure data: shifted left one character per byte sent.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    ready_d = ready_q;
    line_d  = line_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = S_INIT;
          phase_d = PH_SETUP;
          idx_d   = '0;
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_IDLE: begin
        if (grant0 || grant1) begin
          state_d = S_ADDR;
          phase_d = PH_SETUP;
          rs_d    = 1'b0;
          sel_d   = grant1;
          last_d  = grant1;
          data_d  = grant1 ? 8'hC0 : 8'h80;
          line_d  = grant1 ? line1 : line0;
          ack0_d  = grant0;
          ack1_d  = grant1;
        end
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_EN;
            cnt_d   = EN_LD;
          end
          PH_EN: begin
            if (cnt_q == '0) begin
              phase_d = PH_WAIT;
              cnt_d   = (state_q == S_INIT && idx_q == 4'd3) ? CLR_LD : CMD_LD;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else begin
              // End of a byte slot: pick the next byte or leave the phase.
              phase_d = PH_SETUP;
              if (state_q == S_INIT) begin
                if (idx_q == 4'd3) begin
                  state_d = S_IDLE;
                  ready_d = 1'b1;
                end else begin
                  idx_d  = idx_q + 4'd1;
                  data_d = init_cmd(idx_q[1:0] + 2'd1);
                end
              end else if (state_q == S_ADDR) begin
                state_d = S_CHAR;
                idx_d   = '0;
                rs_d    = 1'b1;
                data_d  = line_q[127:120];
                line_d  = {line_q[119:0], 8'h00};
              end else if (idx_q == 4'd15) begin
                state_d = S_IDLE;
                done0_d = !sel_q;
                done1_d = sel_q;
              end else begin
                idx_d  = idx_q + 4'd1;
                data_d = line_q[127:120];
                line_d = {line_q[119:0], 8'h00};
              end
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    lcd_en = 1'b0;
    if (phase_q == PH_EN && (state_q == S_INIT || state_q == S_ADDR || state_q == S_CHAR))
      lcd_en = 1'b1;
    busy = (state_q != S_IDLE);
  end

  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = data_q;
  assign ready    = ready_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Bench for lcd_line_arbiter: bus-byte scoreboard plus timed ack/done/ready checks.
module tb_lcd_line_arbiter;

  localparam logic [127:0] LA = "ABCDEFGHIJKLMNOP";
  localparam logic [127:0] LB = "bottom row text!";
  localparam logic [127:0] LT = "12:34:56        ";

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [127:0] line0 = LA, line1 = LB;
  logic         ack0, ack1, done0, done1, ready, busy;
  logic         lcd_en, lcd_rs, lcd_rw;
  logic [7:0]   lcd_data;

  lcd_line_arbiter #(
    .EN_HIGH_CYC(2), .CMD_WAIT_CYC(3), .CLR_WAIT_CYC(5), .PWRUP_WAIT_CYC(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .line0(line0), .req1(req1), .line1(line1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .ready(ready), .busy(busy),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int n_rise = 0, hi_cnt = 0;
  int n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0;
  logic prev_en = 1'b0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic         side;
    logic [127:0] line;
    logic [7:0]   addr;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic wait_for(input string nm, input int which, input int max);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      case (which)
        0: ok = ack0;
        1: ok = ack1;
        2: ok = done0;
        3: ok = done1;
        4: ok = ready;
        5: ok = lcd_en;
        6: ok = ack0 | ack1;
        default: ok = done0 | done1;
      endcase
      if (ok) break;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout %s: got no event, required one within %0d cycles", nm, max);
    end
  endtask

  task automatic push_line(input logic [7:0] addr, input logic [127:0] ln);
    exp_q.push_back({1'b0, addr});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, ln[127-8*i -: 8]});
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  // Bus monitor: each EN rising edge pops one expected {rs,data}; EN width must be 2.
  always @(negedge clk) begin
    logic [8:0] e;
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
    if (done0) n_done0++;
    if (done1) n_done1++;
    if (!rst_n) begin
      prev_en = 1'b0;
      hi_cnt  = 0;
    end else begin
      if (lcd_en && !prev_en) begin
        n_rise++;
        hi_cnt = 1;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL bus byte: got unexpected rs=%0b data=0x%0h, required none", lcd_rs, lcd_data);
        end else begin
          e = exp_q.pop_front();
          check("bus byte", 32'({lcd_rs, lcd_data}), 32'(e));
          check("rw low", 32'(lcd_rw), 32'd0);
        end
      end else if (lcd_en) begin
        hi_cnt++;
      end else if (prev_en) begin
        check("en width", 32'(hi_cnt), 32'd2);
      end
      prev_en = lcd_en;
    end
  end

  initial begin
    int rel, a, d, prev_d, r0;

    tbl[0] = '{side: 1'b0, line: LA, addr: 8'h80};
    tbl[1] = '{side: 1'b1, line: LB, addr: 8'hC0};
    tbl[2] = '{side: 1'b0, line: LA, addr: 8'h80};
    tbl[3] = '{side: 1'b1, line: LB, addr: 8'hC0};

    // Reset state and initialisation sequence with no requests
    repeat (3) @(negedge clk);
    check("reset lcd_en", 32'(lcd_en), 32'd0);
    check("reset lcd_rs", 32'(lcd_rs), 32'd0);
    check("reset lcd_rw", 32'(lcd_rw), 32'd0);
    check("reset lcd_data", 32'(lcd_data), 32'h00);
    check("reset acks", 32'({ack0, ack1}), 32'd0);
    check("reset dones", 32'({done0, done1}), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset busy", 32'(busy), 32'd1);
    push_init();
    rst_n = 1'b1;
    rel = cyc;
    wait_for("first en", 5, 50);
    check("first en cycle", 32'(cyc - rel), 32'd11);
    wait_for("ready", 4, 100);
    check("ready cycle", 32'(cyc - rel), 32'd36);
    check("busy at ready", 32'(busy), 32'd0);

    // Both requests held: table-driven round-robin
    for (int i = 0; i < 4; i++) push_line(tbl[i].addr, tbl[i].line);
    req0 = 1'b1;
    req1 = 1'b1;
    prev_d = 0;
    for (int i = 0; i < 4; i++) begin
      wait_for("rr ack", 6, 300);
      a = cyc;
      check("rr ack side", 32'({ack1, ack0}), tbl[i].side ? 32'd2 : 32'd1);
      if (i > 0) check("rr ack gap", 32'(a - prev_d), 32'd1);
      wait_for("rr done", 7, 200);
      d = cyc;
      check("rr done side", 32'({done1, done0}), tbl[i].side ? 32'd2 : 32'd1);
      check("rr line length", 32'(d - a), 32'd102);
      prev_d = d;
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Single top-row write, line changed after ack, short req1 never served
    line0 = LT;
    push_line(8'h80, LT);
    req0 = 1'b1;
    wait_for("ack0 single", 0, 20);
    a = cyc;
    check("en low at ack", 32'(lcd_en), 32'd0);
    req0  = 1'b0;
    line0 = '1;
    req1  = 1'b1;
    @(negedge clk);
    check("ack0 width", 32'(ack0), 32'd0);
    check("en one after ack", 32'(lcd_en), 32'd1);
    repeat (3) @(negedge clk);
    req1 = 1'b0;
    wait_for("done0 single", 2, 200);
    check("single line length", 32'(cyc - a), 32'd102);
    repeat (10) @(negedge clk);
    check("dropped req1 not served", 32'(n_ack1), 32'd2);
    check("idle busy", 32'(busy), 32'd0);
    check("idle ready", 32'(ready), 32'd1);

    // Reset during the 5th character, then request during init
    line0 = LA;
    push_line(8'h80, LA);
    req0 = 1'b1;
    wait_for("ack0 abort", 0, 20);
    req0 = 1'b0;
    r0 = n_rise;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (n_rise >= r0 + 6) break;
    end
    check("reached 5th char", 32'(n_rise - r0), 32'd6);
    #1 rst_n = 1'b0;
    #1;
    check("abort lcd_en", 32'(lcd_en), 32'd0);
    check("abort lcd_data", 32'(lcd_data), 32'h00);
    check("abort busy", 32'(busy), 32'd1);
    check("abort ready", 32'(ready), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    rel = cyc;
    repeat (3) @(negedge clk);
    req1 = 1'b1;
    push_line(8'hC0, LB);
    wait_for("ready again", 4, 100);
    check("ready again cycle", 32'(cyc - rel), 32'd36);
    wait_for("ack1 after init", 1, 10);
    check("ack1 after init cycle", 32'(cyc - rel), 32'd37);
    a = cyc;
    req1 = 1'b0;
    wait_for("done1 after init", 3, 200);
    check("bottom line length", 32'(cyc - a), 32'd102);
    repeat (5) @(negedge clk);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    check("ack0 count", 32'(n_ack0), 32'd4);
    check("ack1 count", 32'(n_ack1), 32'd3);
    check("done0 count", 32'(n_done0), 32'd3);
    check("done1 count", 32'(n_done1), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
